// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - parametrised UART transmitter, LSB first, line idles high
// One word per send/ready handshake; registered line output and one-cycle done strobe.
module uart_tx_frame_gen #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 done,
  output logic                 UART_TX
);

  localparam int              TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      D_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      S_LAST = 4'(STOP_BITS - 1);
  localparam bit              PAR_EN = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        timer, timer_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic                 tx_n, done_n;
  logic                 bit_end;

  assign ready   = (state == S_IDLE);
  assign bit_end = (timer == T_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      UART_TX <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bit <= par_n;
      UART_TX <= tx_n;
      done    <= done_n;
    end
  end

  // The line value for the next bit is loaded on the same edge the state advances,
  // so UART_TX only ever changes on bit boundaries.
  always_comb begin
    state_n = state;
    timer_n = bit_end ? '0 : timer + TW'(1);
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_bit;
    tx_n    = UART_TX;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        timer_n = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        if (send) begin
          state_n = S_START;
          shift_n = data;
          par_n   = (PARITY == 2) ? ^data : ~^data;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = shift[0];
          shift_n = shift >> 1;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx == D_LAST) begin
            idx_n = '0;
            if (PAR_EN) begin
              state_n = S_PAR;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + 4'd1;
            tx_n    = shift[0];
            shift_n = shift >> 1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
          idx_n   = '0;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end) begin
          if (idx == S_LAST) begin
            state_n = S_IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb/tb_uart_tx_frame_gen.sv - scoreboard bench for uart_tx_frame_gen
// Three instances: 8N1, 7E2 and 8O1, all at 4 clocks per bit.
module tb_uart_tx_frame_gen;
  localparam int C = 4;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  n;
    logic        b2b;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       send [3];
  logic       ready [3];
  logic       done [3];
  logic       tx [3];
  logic [7:0] d0, d2;
  logic [6:0] d1;

  item_t exp_q [3][$];
  int    tests = 0;
  int    fails = 0;
  int    done_cnt [3] = '{0, 0, 0};
  int    exp_done [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_tx_frame_gen #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .send(send[0]), .data(d0),
    .ready(ready[0]), .done(done[0]), .UART_TX(tx[0]));
  uart_tx_frame_gen #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .send(send[1]), .data(d1),
    .ready(ready[1]), .done(done[1]), .UART_TX(tx[1]));
  uart_tx_frame_gen #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .send(send[2]), .data(d2),
    .ready(ready[2]), .done(done[2]), .UART_TX(tx[2]));

  function automatic int db(int g); return (g == 1) ? 7 : 8; endfunction
  function automatic int pm(int g); return (g == 1) ? 2 : ((g == 2) ? 1 : 0); endfunction
  function automatic int sb(int g); return (g == 1) ? 2 : 1; endfunction

  // Expected line bits for one frame, built from the framing rules.
  function automatic item_t model(int g, int unsigned w, bit b2b);
    item_t it;
    int    k = 1;
    int    ones = 0;
    it.bits = '1;
    it.b2b  = b2b;
    it.bits[0] = 1'b0;
    for (int i = 0; i < db(g); i++) begin
      it.bits[k] = ((w >> i) & 1) != 0;
      ones += int'((w >> i) & 1);
      k++;
    end
    if (pm(g) != 0) begin
      it.bits[k] = (pm(g) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      k++;
    end
    k += sb(g);
    it.n = 5'(k);
    return it;
  endfunction

  task automatic set_data(int g, int unsigned v);
    case (g)
      0: d0 = v[7:0];
      1: d1 = v[6:0];
      default: d2 = v[7:0];
    endcase
  endtask

  task automatic send_word(int g, int unsigned w);
    int t = 0;
    while ((exp_q[g].size() != 0 || ready[g] !== 1'b1) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      tests++; fails++;
      $display("FAIL ready_wait g%0d: ready=%b, required 1", g, ready[g]);
    end
    set_data(g, w);
    send[g] = 1'b1;
    exp_q[g].push_back(model(g, w, 1'b0));
    exp_done[g]++;
    @(negedge clk);
    send[g] = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 ||
            ready[0] !== 1'b1 || ready[1] !== 1'b1 || ready[2] !== 1'b1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      tests++; fails++;
      $display("FAIL idle_wait: queues=%0d, required 0", exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) if (done[g] === 1'b1) done_cnt[g]++;
  end

  for (genvar g = 0; g < 3; g++) begin : mon
    initial begin
      item_t it;
      int    wt;
      int    bad;
      forever begin
        wait (exp_q[g].size() > 0);
        it = exp_q[g][0];
        wt = 0;
        if (it.b2b) begin
          @(negedge clk);
          tests++;
          if (tx[g] !== 1'b0) begin
            fails++;
            $display("FAIL gap g%0d: line=%b one cycle after done, required 0", g, tx[g]);
          end
        end else begin
          while (tx[g] !== 1'b0 && wt < 400) begin
            @(negedge clk);
            wt++;
          end
        end
        if (wt >= 400) begin
          tests++; fails++;
          $display("FAIL start_timeout g%0d: line=%b, required 0", g, tx[g]);
        end else begin
          bad = 0;
          for (int c = 0; c < it.n * C; c++) begin
            if (c > 0) @(negedge clk);
            if (tx[g] !== it.bits[c / C] || ready[g] !== 1'b0 || done[g] !== 1'b0) bad++;
          end
          tests++;
          if (bad != 0) begin
            fails++;
            $display("FAIL frame g%0d bits=%h: %0d bad cycles, required 0", g, it.bits, bad);
          end
          @(negedge clk);
          tests++;
          if (tx[g] !== 1'b1 || ready[g] !== 1'b1 || done[g] !== 1'b1) begin
            fails++;
            $display("FAIL frame_end g%0d: tx/ready/done=%b%b%b, required 111", g, tx[g], ready[g], done[g]);
          end
        end
        void'(exp_q[g].pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int g = 0; g < 3; g++) send[g] = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      tests++;
      if (tx[g] !== 1'b1 || ready[g] !== 1'b1 || done[g] !== 1'b0) begin
        fails++;
        $display("FAIL reset g%0d: tx/ready/done=%b%b%b, required 110", g, tx[g], ready[g], done[g]);
      end
    end
    rst = 1'b0;
    @(negedge clk);

    send_word(0, 32'h55);
    send_word(1, 32'h03);
    send_word(2, 32'h00);
    send_word(2, 32'hFF);
    wait_idle();

    // send held high across two frames
    d0 = 8'hA5;
    send[0] = 1'b1;
    exp_q[0].push_back(model(0, 32'hA5, 1'b0));
    exp_done[0]++;
    @(negedge clk);
    d0 = 8'h3C;
    exp_q[0].push_back(model(0, 32'h3C, 1'b1));
    exp_done[0]++;
    begin
      int t = 0;
      while (ready[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    end
    @(negedge clk);
    send[0] = 1'b0;
    wait_idle();

    // sends and data changes while busy are ignored
    send_word(0, $urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      d0 = 8'($urandom_range(0, 255));
      send[0] = 1'b1;
      @(negedge clk);
      send[0] = 1'b0;
    end
    wait_idle();

    // reset in the middle of frame bit 3
    d0 = 8'($urandom_range(0, 255));
    send[0] = 1'b1;
    @(negedge clk);
    send[0] = 1'b0;
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || done[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: tx/ready/done=%b%b%b, required 110", tx[0], ready[0], done[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    send_word(0, 32'hC3);
    wait_idle();

    for (int i = 0; i < 8; i++)
      for (int g = 0; g < 3; g++) send_word(g, $urandom);
    wait_idle();
    repeat (5) @(negedge clk);

    for (int g = 0; g < 3; g++) begin
      tests++;
      if (done_cnt[g] != exp_done[g]) begin
        fails++;
        $display("FAIL done_count g%0d: %0d pulses, required %0d", g, done_cnt[g], exp_done[g]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
